// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 9600;
  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int DATA_BITS  = 8;
  localparam bit PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic parity_of(
    input logic [DATA_BITS-1:0] d
  );
    return PARITY_EVEN ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake into the transmitter: data/valid in, ready out.
// master = word producer, slave = uart_tx.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Input buffer: DEPTH x W synchronous FIFO, async active-low reset.
// Ports: push/din in, pop/dout out (head word), full, empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         CLK50MHz,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr;
  logic          rd;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign dout  = mem[rp];

  always_ff @(posedge CLK50MHz) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8 data bits, even parity, 1 stop bit.
// Ports: CLK50MHz, RESET (async low), bus (word handshake), TX, BUSY.
module uart_tx #(
  parameter int CLK_HZ = uart_pkg::CLK_HZ,
  parameter int BAUD   = uart_pkg::BAUD,
  parameter int DEPTH  = 4
) (
  input  logic      CLK50MHz,
  input  logic      RESET,
  uart_tx_if.slave  bus,
  output logic      TX,
  output logic      BUSY
);
  import uart_pkg::*;

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW = $clog2(BIT_CYC);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST  = CW'(BIT_CYC - 1);
  localparam logic [IW-1:0] LASTB = IW'(DATA_BITS - 1);

  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] head;
  logic par, par_n;
  logic tx_q, tx_n;
  logic push, pop, full, empty;
  logic last;

  assign bus.ready = ~full;
  assign push = bus.valid & ~full;
  assign last = (cnt == LAST);
  assign TX   = tx_q;
  assign BUSY = (st != IDLE) | ~empty;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_BITS)
  ) u_fifo (
    .CLK50MHz (CLK50MHz),
    .RESET    (RESET),
    .push     (push),
    .pop      (pop),
    .din      (bus.data),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      st   <= IDLE;
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      par  <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      idx  <= idx_n;
      sh   <= sh_n;
      par  <= par_n;
      tx_q <= tx_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    idx_n = idx;
    sh_n  = sh;
    par_n = par;
    tx_n  = tx_q;
    pop   = 1'b0;
    if (st != IDLE) cnt_n = last ? '0 : cnt + 1'b1;
    unique case (st)
      IDLE: begin
        pop   = ~empty;
        tx_n  = 1'b1;
      end
      START: begin
        if (last) begin
          st_n  = DATA;
          idx_n = '0;
          tx_n  = sh[0];
        end
      end
      DATA: begin
        if (last) begin
          if (idx == LASTB) begin
            st_n = PARITY;
            tx_n = par;
          end else begin
            idx_n = idx + 1'b1;
            sh_n  = {1'b0, sh[DATA_BITS-1:1]};
            tx_n  = sh[1];
          end
        end
      end
      PARITY: begin
        if (last) begin
          st_n = STOP;
          tx_n = 1'b1;
        end
      end
      STOP: begin
        if (last) begin
          pop  = ~empty;
          st_n = IDLE;
          tx_n = 1'b1;
        end
      end
      default: begin
        st_n = IDLE;
        tx_n = 1'b1;
      end
    endcase
    // Loading from IDLE or straight out of STOP gives gap-free frames.
    if (pop) begin
      sh_n  = head;
      par_n = parity_of(head);
      tx_n  = 1'b0;
      cnt_n = '0;
      st_n  = START;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx.
// Expected line levels come from a frame-level model of accepted words.
module tb_uart_tx;

  localparam int CLK_HZ = 1234;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int B      = CLK_HZ / BAUD;

  logic CLK50MHz = 1'b0;
  logic RESET = 1'b0;
  logic TX;
  logic BUSY;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK50MHz (CLK50MHz),
    .RESET    (RESET),
    .bus      (bus),
    .TX       (TX),
    .BUSY     (BUSY)
  );

  always #5 CLK50MHz = ~CLK50MHz;

  int checks = 0;
  int passed = 0;

  logic [7:0] wq [$];
  logic [7:0] acc [$];
  logic s_tx [$];
  logic s_busy [$];
  logic s_rdy [$];

  // Line bits in send order: start, D0..D7, even parity, stop.
  function automatic logic [10:0] frame(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  // Sample c is taken after edge c; first accept on edge 1,
  // first start bit after edge 2, frames back to back after that.
  function automatic logic exp_tx(input int c);
    int j, w, b;
    logic [10:0] f;
    j = c - 2;
    if (j < 0 || j >= 11 * B * acc.size()) return 1'b1;
    w = j / (11 * B);
    b = (j / B) % 11;
    f = frame(acc[w]);
    return f[b];
  endfunction

  // Offer wq words while c < vmax; record outputs every cycle.
  task automatic run(input int vmax, input int n);
    int wi;
    wi = 0;
    acc.delete();
    s_tx.delete();
    s_busy.delete();
    s_rdy.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge CLK50MHz);
      s_tx.push_back(TX);
      s_busy.push_back(BUSY);
      s_rdy.push_back(bus.ready);
      if (c < vmax && wi < wq.size()) begin
        bus.data  = wq[wi];
        bus.valid = 1'b1;
        if (bus.ready) begin
          acc.push_back(wq[wi]);
          wi++;
        end
      end else begin
        bus.valid = 1'b0;
        bus.data  = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    RESET = 1'b0;
    repeat (3) @(negedge CLK50MHz);
    checks++;
    if (TX !== 1'b1) $display("FAIL reset_tx: got %b want 1", TX);
    else passed++;
    checks++;
    if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY);
    else passed++;
    checks++;
    if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready);
    else passed++;
    RESET = 1'b1;
  endtask

  task automatic test_idle;
    int btx, bbusy, brdy;
    btx = 0; bbusy = 0; brdy = 0;
    wq.delete();
    run(0, 1000);
    foreach (s_tx[c]) begin
      if (s_tx[c] !== 1'b1) btx++;
      if (s_busy[c] !== 1'b0) bbusy++;
      if (s_rdy[c] !== 1'b1) brdy++;
    end
    checks++;
    if (btx != 0) $display("FAIL idle_tx: %0d cycles not 1, want 0", btx);
    else passed++;
    checks++;
    if (bbusy != 0) $display("FAIL idle_busy: %0d cycles busy, want 0", bbusy);
    else passed++;
    checks++;
    if (brdy != 0) $display("FAIL idle_ready: %0d cycles not ready, want 0", brdy);
    else passed++;
  endtask

  task automatic test_single(input string tag, input logic [7:0] w);
    int e, bad;
    wq = {w};
    run(1, 2 + 11 * B + 4);
    checks++;
    if (acc.size() != 1) $display("FAIL %s_accept: got %0d words want 1", tag, acc.size());
    else passed++;
    for (int b = 0; b < 11 * acc.size(); b++) begin
      int nb;
      logic got;
      nb = 0;
      got = 1'b0;
      for (int k = 0; k < B; k++)
        if (s_tx[2+b*B+k] !== exp_tx(2+b*B+k)) begin
          nb++;
          got = s_tx[2+b*B+k];
        end
      checks++;
      if (nb != 0)
        $display("FAIL %s_bit%0d: TX=%b in %0d cycles, want %b", tag, b, got, nb, exp_tx(2+b*B));
      else passed++;
    end
    e = 2 + 11 * B;
    bad = 0;
    for (int c = e; c < s_tx.size(); c++) if (s_tx[c] !== 1'b1) bad++;
    checks++;
    if (bad != 0) $display("FAIL %s_tail: %0d idle cycles not 1, want 0", tag, bad);
    else passed++;
    checks++;
    if ({s_busy[e-1], s_busy[e]} !== 2'b10)
      $display("FAIL %s_busy_fall: got %b%b want 10", tag, s_busy[e-1], s_busy[e]);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int hi, c;
    wq = {8'hA5, 8'h3C};
    run(2, 2 + 22 * B + 4);
    checks++;
    if (acc.size() != 2) $display("FAIL b2b_accept: got %0d words want 2", acc.size());
    else passed++;
    for (int b = 0; b < 11 * acc.size(); b++) begin
      int nb;
      logic got;
      nb = 0;
      got = 1'b0;
      for (int k = 0; k < B; k++)
        if (s_tx[2+b*B+k] !== exp_tx(2+b*B+k)) begin
          nb++;
          got = s_tx[2+b*B+k];
        end
      checks++;
      if (nb != 0)
        $display("FAIL b2b_bit%0d: TX=%b in %0d cycles, want %b", b, got, nb, exp_tx(2+b*B));
      else passed++;
    end
    hi = 0;
    c = 2;
    while (c < s_busy.size() && s_busy[c] === 1'b1) begin
      hi++;
      c++;
    end
    checks++;
    if (hi != 22 * B) $display("FAIL b2b_busy_len: got %0d want %0d", hi, 22 * B);
    else passed++;
  endtask

  task automatic test_fill;
    int e;
    logic [5:0] rv;
    wq.delete();
    repeat (6) wq.push_back(8'($urandom));
    run(6, 2 + 55 * B + 4);
    checks++;
    if (acc.size() != 5) $display("FAIL fill_accept: got %0d words want 5", acc.size());
    else passed++;
    rv = {s_rdy[0], s_rdy[1], s_rdy[2], s_rdy[3], s_rdy[4], s_rdy[5]};
    checks++;
    if (rv !== 6'b111110) $display("FAIL fill_ready_seq: got %b want 111110", rv);
    else passed++;
    e = 2 + 11 * B;
    checks++;
    if ({s_rdy[e-1], s_rdy[e]} !== 2'b01)
      $display("FAIL fill_ready_back: got %b%b want 01", s_rdy[e-1], s_rdy[e]);
    else passed++;
    for (int b = 0; b < 11 * acc.size(); b++) begin
      int nb;
      logic got;
      nb = 0;
      got = 1'b0;
      for (int k = 0; k < B; k++)
        if (s_tx[2+b*B+k] !== exp_tx(2+b*B+k)) begin
          nb++;
          got = s_tx[2+b*B+k];
        end
      checks++;
      if (nb != 0)
        $display("FAIL fill_bit%0d: TX=%b in %0d cycles, want %b", b, got, nb, exp_tx(2+b*B));
      else passed++;
    end
    checks++;
    if (s_busy[2+55*B] !== 1'b0)
      $display("FAIL fill_busy_end: got %b want 0", s_busy[2+55*B]);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    int bad;
    wq = {8'hFF, 8'($urandom), 8'($urandom)};
    run(3, 2 + 4 * B + B / 2);
    checks++;
    if (acc.size() != 3 || s_busy[2+4*B] !== 1'b1)
      $display("FAIL rst_setup: got %0d words busy=%b want 3 busy=1", acc.size(), s_busy[2+4*B]);
    else passed++;
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (TX !== 1'b1) $display("FAIL rst_async_tx: got %b want 1", TX);
    else passed++;
    checks++;
    if (BUSY !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", BUSY);
    else passed++;
    checks++;
    if (bus.ready !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", bus.ready);
    else passed++;
    repeat (2) @(negedge CLK50MHz);
    RESET = 1'b1;
    wq.delete();
    run(0, 30 * B);
    bad = 0;
    foreach (s_tx[c]) if (s_tx[c] !== 1'b1 || s_busy[c] !== 1'b0) bad++;
    checks++;
    if (bad != 0) $display("FAIL rst_no_resume: %0d active cycles, want 0", bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single("w55", 8'h55);
    test_single("w07", 8'h07);
    repeat (3) test_single("rnd", 8'($urandom));
    test_back_to_back();
    test_fill();
    test_reset_midframe();
    test_single("post_rst", 8'($urandom));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, SHALL be the input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL be the line rate in bits/s.
REQ-003 Parameter DEPTH, default 4, SHALL be the number of input-buffer entries (power of two, >= 2).
REQ-004 CLK50MHz  input  1  SHALL be the system clock; all logic is on its rising edge.
REQ-005 RESET  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 DATA  input  8  SHALL be the word to transmit; DATA[0] is sent first.
REQ-007 VALID  input  1  SHALL be high when DATA holds a word to queue.
REQ-008 READY  output  1  SHALL be high when the buffer can accept a word.
REQ-009 TX  output  1  SHALL be the serial line, idle high, driven from a flop.
REQ-010 BUSY  output  1  SHALL be high while a frame is on the line or the buffer is non-empty.

Function
REQ-011 Frame SHALL be: 1 start bit (0), D0..D7 LSB first, 1 even-parity bit, 1 stop bit (1); 11 bits total.
REQ-012 Parity bit SHALL equal XOR of D[7:0], so that data plus parity holds an even number of ones.
REQ-013 Bit period SHALL be BIT_CYCLES = CLK_HZ/BAUD, integer-truncated (5208 at defaults); every bit, including stop, SHALL last exactly BIT_CYCLES clocks.
REQ-014 Bit-period counter SHALL be 13 bits at defaults, count 0..BIT_CYCLES-1, and wrap to 0 at each bit boundary; there is no free-running tick.
REQ-015 A word SHALL be written to the buffer on any edge where VALID and READY are both high; VALID without READY SHALL have no effect.
REQ-016 READY SHALL be 1 when buffer count < DEPTH and 0 when full; a pop in the same cycle SHALL NOT make a full buffer accept.
REQ-017 Buffer SHALL be FIFO-ordered; a push and a pop in the same cycle SHALL both take effect and leave the count unchanged.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with the buffer non-empty, the FSM SHALL pop the head word into a shift register, compute its parity, drive TX=0, and enter START.
REQ-020 Latency: with IDLE and an empty buffer, a word accepted at edge k SHALL drive TX low from edge k+1.
REQ-021 START -> DATA, DATA (8 bits, bit index 0..7) -> PARITY, and PARITY -> STOP SHALL each occur at the end of a full bit period.
REQ-022 At the end of STOP, the FSM SHALL pop the next word and enter START directly if the buffer is non-empty (no idle gap); otherwise it SHALL enter IDLE with TX=1.
REQ-023 DATA changes after acceptance SHALL NOT affect a queued or in-flight frame.
REQ-024 BUSY SHALL fall in the same cycle the FSM enters IDLE with the buffer empty.

Reset
REQ-025 RESET low SHALL immediately force TX=1, BUSY=0, FSM=IDLE, buffer count, pointers and counters to 0, and READY=1.
REQ-026 Reset mid-frame SHALL abort the frame and discard all buffered words; after release, no partial frame SHALL be resumed.
REQ-027 The first frame after reset release SHALL start only on a new VALID/READY acceptance.

Structure
REQ-028 Shared package uart_pkg SHALL hold CLK_HZ, BAUD, BIT_CYCLES, DATA_BITS=8, the parity mode (even), and the FSM state encoding, for use by the receiver and the transmitter.
REQ-029 The buffer SHALL be a sub-module uart_tx_fifo (synchronous, DEPTH x 8, push/pop/full/empty, asynchronous active-low reset).

Verification
REQ-030 Send 0x55 once -> TX levels 0,1,0,1,0,1,0,1,0,0,1, each held 5208 clocks, then idle 1; BUSY is low afterwards.
REQ-031 Send 0x07 -> TX levels 0,1,1,1,0,0,0,0,0,1,1; parity bit = 1.
REQ-032 Assert VALID for 6 consecutive clocks from idle -> 5 words accepted, READY=0 on the 6th clock, READY returns high when the second frame is popped.
REQ-033 Queue 0xA5 and 0x3C back-to-back -> the second start bit begins on the clock immediately after the first stop bit ends; total 22*5208 clocks with BUSY high.
REQ-034 Assert RESET during the D3 bit of 0xFF with 2 words queued -> TX=1 asynchronously, READY=1, and no further frames are sent after release.
REQ-035 Hold VALID=0 for 100000 clocks after reset -> TX remains 1, BUSY=0, READY=1.
